cls_fault_handler: RTL
======================

CLS_FAULT_HANDLER -- requirements
Module: cls_fault_handler

Interface
REQ-001 Parameter RST_CYCLES, default 16, number of cycles core reset is held per recovery (range 1..255).
REQ-002 Parameter SETTLE_CYCLES, default 4, number of post-release cycles during which fault inputs are ignored (range 1..255).
REQ-003 Parameter MAX_FAULTS, default 3, windowed fault count that triggers fatal lockout (range 1..15).
REQ-004 Parameter WINDOW_CYCLES, default 1024, leak period of the windowed counter (power of two, 2..65536).
REQ-005 Parameter CNT_W, default 8, width of the total fault counter.
REQ-006 Ports are listed below, clock and reset first; there is one clock, and reset is asynchronous and active-low.
REQ-007 clk_i  in  1  core clock.
REQ-008 rst_ni  in  1  asynchronous active-low reset.
REQ-009 fault_valid_i  in  1  comparator reports a lockstep mismatch this cycle.
REQ-010 fault_mask_i  in  3  disagreeing core(s): bit0 master, bit1 slave1, bit2 slave2.
REQ-011 irq_ack_i  in  1  software acknowledge; clears fault_irq_o.
REQ-012 core_rst_no  out  1  active-low reset to all three cores.
REQ-013 fault_irq_o  out  1  sticky fault interrupt.
REQ-014 fatal_o  out  1  lockout indication.
REQ-015 last_mask_o  out  3  mask of the most recently accepted fault.
REQ-016 fault_cnt_o  out  CNT_W  saturating count of accepted faults.

Function
REQ-017 FSM states SHALL be IDLE, HOLD, SETTLE and FATAL.
REQ-018 A fault is "accepted" only when fault_valid_i=1 in IDLE; in HOLD, SETTLE and FATAL, fault inputs SHALL be ignored: not counted, not latched, no irq.
REQ-019 On an accepted fault in cycle N, at edge N+1: core_rst_no=0, fault_irq_o=1, last_mask_o=fault_mask_i, fault_cnt_o+=1 (saturating at 2^CNT_W-1), window count +=1.
REQ-020 After an accepted fault, the next state SHALL be FATAL if the incremented window count equals MAX_FAULTS, otherwise HOLD.
REQ-021 HOLD: core_rst_no=0 for exactly RST_CYCLES cycles, then SETTLE with core_rst_no=1.
REQ-022 SETTLE: core_rst_no=1 for exactly SETTLE_CYCLES cycles, then IDLE.
REQ-023 FATAL: core_rst_no=0 and fatal_o=1 permanently, until rst_ni is asserted.
REQ-024 fault_irq_o SHALL clear on the cycle after irq_ack_i=1; if an accepted fault and irq_ack_i occur in the same cycle, the set wins.
REQ-025 fault_mask_i=3'b000 with fault_valid_i=1 SHALL still be accepted, with last_mask_o=3'b000.
REQ-026 The window count SHALL be 4 bits wide and saturate at 15.

Reset
REQ-027 While rst_ni=0: state=IDLE, core_rst_no=0, fault_irq_o=0, fatal_o=0, last_mask_o=0, fault_cnt_o=0, window count=0, all timers=0.
REQ-028 On the first edge after rst_ni deasserts, core_rst_no SHALL go to 1; assertion of rst_ni mid-HOLD/SETTLE/FATAL SHALL abort to reset values immediately.

Configuration
REQ-029 With macro CLS_FAULT_WINDOW_EN defined: a free-running period counter SHALL decrement a nonzero window count by 1 every WINDOW_CYCLES cycles; a simultaneous increment and decrement leaves the count unchanged.
REQ-030 Without CLS_FAULT_WINDOW_EN: the window count only increments, so FATAL is entered on the MAX_FAULTS-th accepted fault since reset; the period counter is not instantiated.

Structure
REQ-031 Shared package cls_pkg SHALL hold the FSM state enum, the 3-bit fault mask typedef, and the mask bit-index constants.
REQ-032 Sub-module cls_cycle_timer (loadable 8-bit down-counter with a done flag) SHALL be used for the HOLD and SETTLE timing.

Verification
REQ-033 One fault, mask=3'b010, defaults: core_rst_no low for exactly 16 cycles, high for 4 SETTLE cycles, then IDLE; fault_irq_o=1, last_mask_o=3'b010, fault_cnt_o=1.
REQ-034 fault_valid_i held high during HOLD and SETTLE: fault_cnt_o stays 1 and last_mask_o is unchanged.
REQ-035 Three faults, each accepted in IDLE, macro off: the third sets fatal_o=1 and core_rst_no=0 permanently; a fourth fault_valid_i produces no change; rst_ni pulse clears all outputs.
REQ-036 Macro on, WINDOW_CYCLES=64, faults spaced 200 cycles apart: fatal_o never asserts across 10 faults; fault_cnt_o=10.
REQ-037 irq_ack_i coincident with an accepted fault: fault_irq_o remains 1; a later ack alone clears it on the next cycle.
REQ-038 rst_ni asserted on cycle 5 of HOLD: all outputs at reset values asynchronously, and core_rst_no=1 one edge after release.

Source files
------------

// File: rtl/cls_pkg.sv
// Shared types and constants for the lockstep fault handler.
// Holds the FSM state enum, the fault mask typedef and mask bit indices.
package cls_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_SETTLE,
      ST_FATAL
   } cls_state_e;

   typedef logic [2:0] cls_mask_t;

   localparam int unsigned MASK_MASTER = 0;
   localparam int unsigned MASK_SLAVE1 = 1;
   localparam int unsigned MASK_SLAVE2 = 2;

   localparam int unsigned WIN_W   = 4;
   localparam logic [3:0]  WIN_MAX = 4'hF;

endpackage

// File: rtl/cls_cycle_timer.sv
// Loadable 8-bit down-counter; done_o is high while the count is zero.
// Ports: clk_i, rst_ni, load_i/load_val_i (load), dec_i (count down), done_o.
module cls_cycle_timer (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       load_i,
   input  logic [7:0] load_val_i,
   input  logic       dec_i,
   output logic       done_o
);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (dec_i && (cnt_q != 8'd0)) begin
         cnt_d = cnt_q - 8'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == 8'd0);

endmodule

// File: rtl/cls_fault_handler.sv
// Lockstep fault handler: resets the cores on a mismatch, raises a sticky irq,
// and locks out after MAX_FAULTS windowed faults.
// Ports: clk_i, rst_ni, fault_valid_i, fault_mask_i, irq_ack_i in;
// core_rst_no, fault_irq_o, fatal_o, last_mask_o, fault_cnt_o out.
// Macro CLS_FAULT_WINDOW_EN enables leaking of the window count.
module cls_fault_handler
   import cls_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = 16,
   parameter int unsigned SETTLE_CYCLES = 4,
   parameter int unsigned MAX_FAULTS    = 3,
   parameter int unsigned WINDOW_CYCLES = 1024,
   parameter int unsigned CNT_W         = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             fault_valid_i,
   input  cls_mask_t        fault_mask_i,
   input  logic             irq_ack_i,
   output logic             core_rst_no,
   output logic             fault_irq_o,
   output logic             fatal_o,
   output cls_mask_t        last_mask_o,
   output logic [CNT_W-1:0] fault_cnt_o
);

   // Timers are loaded with N-1 so a phase lasts exactly N cycles.
   localparam logic [7:0] HOLD_LOAD   = 8'(RST_CYCLES - 1);
   localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
   localparam logic [3:0] WIN_LIMIT   = 4'(MAX_FAULTS);

   cls_state_e       state_q, state_d;
   logic             core_rst_q, core_rst_d;
   logic             irq_q, irq_d;
   logic             fatal_q, fatal_d;
   cls_mask_t        mask_q, mask_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       win_q, win_d;
   logic [3:0]       win_inc;

   logic       accept;
   logic       fatal_hit;
   logic       tmr_load;
   logic [7:0] tmr_val;
   logic       tmr_dec;
   logic       tmr_done;

   assign accept    = fault_valid_i && (state_q == ST_IDLE);
   assign win_inc   = (win_q == WIN_MAX) ? win_q : win_q + 4'd1;
   assign fatal_hit = (win_inc == WIN_LIMIT);

   cls_cycle_timer u_timer (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .dec_i      (tmr_dec),
      .done_o     (tmr_done)
   );

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = fatal_hit ? ST_FATAL : ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (tmr_done) state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (tmr_done) state_d = ST_IDLE;
         end
         ST_FATAL: state_d = ST_FATAL;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output / timer control logic
   always_comb begin
      tmr_load   = 1'b0;
      tmr_val    = 8'd0;
      tmr_dec    = 1'b0;
      core_rst_d = (state_d == ST_IDLE) || (state_d == ST_SETTLE);
      fatal_d    = (state_d == ST_FATAL);
      unique case (state_q)
         ST_IDLE: begin
            if (accept && !fatal_hit) begin
               tmr_load = 1'b1;
               tmr_val  = HOLD_LOAD;
            end
         end
         ST_HOLD: begin
            if (tmr_done) begin
               tmr_load = 1'b1;
               tmr_val  = SETTLE_LOAD;
            end else begin
               tmr_dec = 1'b1;
            end
         end
         ST_SETTLE: tmr_dec = 1'b1;
         default:   tmr_dec = 1'b0;
      endcase
   end

   // Fault bookkeeping; a new fault beats a same-cycle ack.
   always_comb begin
      irq_d  = irq_q;
      mask_d = mask_q;
      cnt_d  = cnt_q;
      if (accept) begin
         irq_d  = 1'b1;
         mask_d = fault_mask_i;
         if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
      end else if (irq_ack_i) begin
         irq_d = 1'b0;
      end
   end

`ifdef CLS_FAULT_WINDOW_EN
   localparam int unsigned PER_W = $clog2(WINDOW_CYCLES);

   logic [PER_W-1:0] per_q, per_d;
   logic             win_dec;

   assign per_d   = per_q + 1'b1;
   assign win_dec = (&per_q) && (win_q != 4'd0);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         per_q <= '0;
      end else begin
         per_q <= per_d;
      end
   end

   always_comb begin
      win_d = win_q;
      if (accept && !win_dec) begin
         win_d = win_inc;
      end else if (!accept && win_dec) begin
         win_d = win_q - 4'd1;
      end
   end
`else
   always_comb begin
      win_d = win_q;
      if (accept) win_d = win_inc;
   end
`endif

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         core_rst_q <= 1'b0;
         irq_q      <= 1'b0;
         fatal_q    <= 1'b0;
         mask_q     <= '0;
         cnt_q      <= '0;
         win_q      <= '0;
      end else begin
         core_rst_q <= core_rst_d;
         irq_q      <= irq_d;
         fatal_q    <= fatal_d;
         mask_q     <= mask_d;
         cnt_q      <= cnt_d;
         win_q      <= win_d;
      end
   end

   assign core_rst_no = core_rst_q;
   assign fault_irq_o = irq_q;
   assign fatal_o     = fatal_q;
   assign last_mask_o = mask_q;
   assign fault_cnt_o = cnt_q;

endmodule
